// File: rtl/ptw_mem_arbiter_pkg.sv
// Shared constants for the page-table-walker / LSU memory port arbiter:
// FSM state encodings, requester indices and pipeline flush codes.
package ptw_mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_BUSY  = 2'd1;
    localparam logic [1:0] ARB_RESP  = 2'd2;
    localparam logic [1:0] ARB_DRAIN = 2'd3;

    localparam int REQ_DMMU = 0;
    localparam int REQ_IMMU = 1;
    localparam int REQ_LSU  = 2;

    // Hazard codes shared with the instruction pipeline.
    localparam logic [3:0] FLUSH_NONE   = 4'h0;
    localparam logic [3:0] FLUSH_ALL    = 4'h1;
    localparam logic [3:0] FLUSH_EXCEPT = 4'h2;

    function automatic logic is_flush(input logic [3:0] hazard);
        return (hazard == FLUSH_ALL) || (hazard == FLUSH_EXCEPT);
    endfunction

endpackage

// File: rtl/ptw_mem_arbiter_pick.sv
// Combinational winner selector: fixed priority with starvation override, or
// round-robin from a pointer when ARB_ROUND_ROBIN_EN is defined.
module ptw_mem_arbiter_pick
    import ptw_mem_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
`ifdef ARB_ROUND_ROBIN_EN
    parameter int IDX_W = 2
`else
    parameter int STARVE_MAX = 15
`endif
) (
    input  logic [N_REQ-1:0]   req_en,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0]   rr_ptr,
`else
    input  logic [N_REQ*4-1:0] starve_cnt,
`endif
    output logic [N_REQ-1:0]   grant,
    output logic               valid
);

    logic found;

`ifdef ARB_ROUND_ROBIN_EN
    int idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req_en[idx] && !found) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        valid = |req_en;
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [N_REQ-1:0] starved;

    // A starved requester beats plain priority; lowest index breaks ties.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++)
            starved[i] = req_en[i] && (starve_cnt[i*4 +: 4] == STARVE_LIM);
        for (int i = 0; i < N_REQ; i++) begin
            if (starved[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (req_en[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        valid = |req_en;
    end
`endif

endmodule

// File: rtl/ptw_mem_arbiter.sv
// Single-outstanding arbiter sharing the memory port between D-MMU, I-MMU and
// LSU, with flush draining. ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module ptw_mem_arbiter
    import ptw_mem_arbiter_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              hazard_signal,
    input  logic [N_REQ-1:0]        req_en,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*32-1:0]     req_wdata,
    output logic [N_REQ-1:0]        req_resolved,
    output logic [31:0]             req_word,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_ack,
    input  logic [31:0]             mem_rdata,
    output logic                    arb_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] grant_q, win_idx;
    logic [N_REQ-1:0] pick_grant;
    logic             pick_valid, flush, take_grant, resp_fire;

    assign flush      = is_flush(hazard_signal);
    assign take_grant = (state_q == ARB_IDLE) && !flush && pick_valid;
    assign resp_fire  = (state_q == ARB_BUSY) && mem_ack && !flush;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    ptw_mem_arbiter_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req_en (req_en),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (take_grant)
            rr_ptr <= (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [N_REQ*4-1:0] starve_cnt;

    ptw_mem_arbiter_pick #(.N_REQ(N_REQ), .STARVE_MAX(STARVE_MAX)) u_pick (
        .req_en     (req_en),
        .starve_cnt (starve_cnt),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_en[i])
                    starve_cnt[i*4 +: 4] <= 4'd0;
                else if (take_grant) begin
                    if (pick_grant[i])
                        starve_cnt[i*4 +: 4] <= 4'd0;
                    else if (starve_cnt[i*4 +: 4] != STARVE_LIM)
                        starve_cnt[i*4 +: 4] <= starve_cnt[i*4 +: 4] + 4'd1;
                end
            end
        end
    end
`endif

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (pick_grant[i]) win_idx = IDX_W'(i);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (take_grant) state_d = ARB_BUSY;
            ARB_BUSY: begin
                if (mem_ack)    state_d = ARB_RESP;
                else if (flush) state_d = ARB_DRAIN;
            end
            ARB_RESP:  state_d = ARB_IDLE;
            ARB_DRAIN: if (mem_ack) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Memory-side outputs follow the next state so they are registered yet
    // assert in the first BUSY cycle; latched values hold until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            arb_busy  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_req  <= (state_d == ARB_BUSY) || (state_d == ARB_DRAIN);
            arb_busy <= (state_d != ARB_IDLE);
            if (take_grant) begin
                grant_q   <= win_idx;
                mem_addr  <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                mem_we    <= req_we[win_idx];
                mem_wdata <= req_wdata[int'(win_idx)*32 +: 32];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            req_resolved[i] = resp_fire && (grant_q == IDX_W'(i));
        req_word = resp_fire ? mem_rdata : 32'h0;
    end

endmodule
